// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared ISA opcodes, ALU op codes, flag bit indices and
// controller state encodings for the 8-bit Von Neumann CPU.
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ALU   = 8'h10;
    localparam logic [7:0] OP_LDA   = 8'h20;
    localparam logic [7:0] OP_STA   = 8'h21;
    localparam logic [7:0] OP_LDB_I = 8'h22;
    localparam logic [7:0] OP_LDA_I = 8'h23;
    localparam logic [7:0] OP_JMP   = 8'h30;
    localparam logic [7:0] OP_JEQ   = 8'h31;
    localparam logic [7:0] OP_JGT   = 8'h32;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    localparam int EQ_BIT  = 0;
    localparam int GRT_BIT = 1;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_CMP
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_IMM, S_ALO, S_AHI, S_LOAD, S_HALT
    } state_e;

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: memory port and ALU port between the controller (master)
// and the RAM/ALU pair (slave).
interface cpu_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rw;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_flags;
    logic [DATA_WIDTH-1:0] alu_c;
    logic [DATA_WIDTH-1:0] alu_new_flags;

    modport master (
        output mem_addr, mem_rw, mem_wdata, alu_op, alu_a, alu_b, alu_flags,
        input  mem_q, alu_c, alu_new_flags
    );

    modport slave (
        input  mem_addr, mem_rw, mem_wdata, alu_op, alu_a, alu_b, alu_flags,
        output mem_q, alu_c, alu_new_flags
    );

endinterface

// File: rtl/cpu_decode.sv
// cpu_decode: combinational opcode classifier.
module cpu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0] op,
    output logic       is_alu,
    output logic       is_imm,
    output logic       is_abs,
    output logic       is_jmp,
    output logic       is_hlt,
    output logic       is_illegal
);

    assign is_alu     = (op & 8'hF0) == OP_ALU && op[3:0] <= ALU_CMP;
    assign is_imm     = op == OP_LDB_I || op == OP_LDA_I;
    assign is_jmp     = op == OP_JMP || op == OP_JEQ || op == OP_JGT;
    assign is_abs     = is_jmp || op == OP_LDA || op == OP_STA;
    assign is_hlt     = op == OP_HLT;
    assign is_illegal = !(is_alu || is_imm || is_abs || is_hlt || op == OP_NOP);

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/execute controller holding PC, A, B, FLAGS, IR
// and the operand-address latch; drives the RAM port and the ALU.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    cpu_ctrl_if.master     bus,
    output logic           halted,
    output logic           illegal
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, flags_q, flags_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d, tmp_q, tmp_d;
    logic                  halted_q, halted_d, illegal_q, illegal_d;
    logic [ADDR_WIDTH-1:0] pc_inc, target;
    logic [7:0]            dec_op;
    logic                  is_alu, is_imm, is_abs, is_jmp, is_hlt, is_illegal;
    logic                  is_cmp, taken;

    // The opcode is only on mem_q during decode; later states classify IR.
    assign dec_op = state_q == S_DECODE ? bus.mem_q : ir_q;

    cpu_decode u_dec (
        .op         (dec_op),
        .is_alu     (is_alu),
        .is_imm     (is_imm),
        .is_abs     (is_abs),
        .is_jmp     (is_jmp),
        .is_hlt     (is_hlt),
        .is_illegal (is_illegal)
    );

    assign pc_inc = pc_q + ADDR_WIDTH'(1);
    assign target = ADDR_WIDTH'({bus.mem_q, tmp_q});
    assign is_cmp = bus.mem_q[3:0] == ALU_CMP;
    assign taken  = ir_q == OP_JMP || (ir_q == OP_JEQ && flags_q[EQ_BIT])
                 || (ir_q == OP_JGT && flags_q[GRT_BIT]);

    assign bus.mem_wdata = a_q;
    assign bus.alu_op    = bus.mem_q[3:0];
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_flags = flags_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        b_d          = b_q;
        flags_d      = flags_q;
        ir_d         = ir_q;
        tmp_d        = tmp_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        bus.mem_addr = pc_q;
        bus.mem_rw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                pc_d    = run ? pc_inc : pc_q;
                state_d = run ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ir_d      = bus.mem_q;
                pc_d      = (is_imm || is_abs) ? pc_inc : pc_q;
                a_d       = (is_alu && !is_cmp) ? bus.alu_c : a_q;
                flags_d   = (is_alu && is_cmp) ? bus.alu_new_flags : flags_q;
                halted_d  = is_hlt || is_illegal;
                illegal_d = illegal_q || is_illegal;
                state_d   = is_imm ? S_IMM : is_abs ? S_ALO
                          : (is_hlt || is_illegal) ? S_HALT : S_FETCH;
            end
            S_IMM: begin
                a_d     = ir_q == OP_LDA_I ? bus.mem_q : a_q;
                b_d     = ir_q == OP_LDB_I ? bus.mem_q : b_q;
                state_d = S_FETCH;
            end
            S_ALO: begin
                tmp_d   = bus.mem_q;
                pc_d    = pc_inc;
                state_d = S_AHI;
            end
            S_AHI: begin
                bus.mem_addr = is_jmp ? pc_q : target;
                bus.mem_rw   = ir_q == OP_STA;
                pc_d         = taken ? target : pc_q;
                state_d      = ir_q == OP_LDA ? S_LOAD : S_FETCH;
            end
            S_LOAD: begin
                a_d     = bus.mem_q;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            a_q       <= '0;
            b_q       <= '0;
            flags_q   <= '0;
            ir_q      <= '0;
            tmp_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            flags_q   <= flags_d;
            ir_q      <= ir_d;
            tmp_q     <= tmp_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
